// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares the physical-memory port between the icache and the dcache.
// Grants one requester at a time and breaks ties round-robin. The granted address,
// write data and read/write direction are latched, and the grant is held until
// memory responds.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   i_pmem_*                 icache side: read request, address, rdata, resp pulse
//   d_pmem_*                 dcache side: read/write request, address, wdata, rdata, resp
//   pmem_*                   memory side: read/write strobes, address, wdata, rdata, resp
module pmem_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // icache side
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  // dcache side
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  // memory side
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StServeI = 2'd1,
    StServeD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_d_q, last_d_d;
  logic                op_write_q, op_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;

  logic req_i, req_d;
  logic grant_i, grant_d;

  assign req_i = i_pmem_read;
  assign req_d = d_pmem_read | d_pmem_write;

  // On a tie, the requester that was not served last wins.
  assign grant_i = req_i & (~req_d | last_d_q);
  assign grant_d = req_d & (~req_i | ~last_d_q);

  // State register. last_d resets to 1 so the icache wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      last_d_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  // Latched transaction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Next-state and latch-enable logic.
  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant_i) begin
          state_d    = StServeI;
          addr_d     = i_pmem_address;
          op_write_d = 1'b0;
        end else if (grant_d) begin
          state_d    = StServeD;
          addr_d     = d_pmem_address;
          // A simultaneous read and write is treated as a writeback.
          op_write_d = d_pmem_write;
          wdata_d    = d_pmem_wdata;
        end
      end
      StServeI: begin
        if (pmem_resp) begin
          state_d  = StIdle;
          last_d_d = 1'b0;
        end
      end
      StServeD: begin
        if (pmem_resp) begin
          state_d  = StIdle;
          last_d_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs. Responses are combinational so they land in the same cycle as pmem_resp.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    pmem_address = addr_q;
    pmem_wdata   = wdata_q;
    i_pmem_rdata = pmem_rdata;
    d_pmem_rdata = pmem_rdata;
    unique case (state_q)
      StServeI: begin
        pmem_read   = ~op_write_q;
        pmem_write  = op_write_q;
        i_pmem_resp = pmem_resp;
      end
      StServeD: begin
        pmem_read   = ~op_write_q;
        pmem_write  = op_write_q;
        d_pmem_resp = pmem_resp;
      end
      default: begin
      end
    endcase
  end

endmodule
